// File: rtl/vga_dac_sequencer.sv
// VGA timing generator and RGB DAC drive sequencer with a one-line calibration ramp
// scheduled into vertical blanking on request.
module vga_dac_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RAMP_LEN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  input  logic       cal_req,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic [7:0] rn,
  output logic [7:0] gn,
  output logic [7:0] bn,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       frame_start,
  output logic       cal_busy,
  output logic       cal_done,
  output logic [1:0] cal_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_ARM    = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] RAMP_END = 10'(RAMP_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } cal_state_t;

  cal_state_t state, state_next;

  logic       line_end;
  logic       arm_point;
  logic       blank_c;
  logic [7:0] r_c, g_c, b_c;

  assign line_end  = (hpos == H_LAST);
  assign arm_point = line_end && (vpos == V_ARM);
  assign blank_c   = (hpos >= H_ACT) || (vpos >= V_ACT);
  assign cal_state = state;

  // ARMED only advances at the last pixel of the final active line, so a request
  // landing on that very cycle naturally waits a full frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cal_req)   state_next = ARMED;
      ARMED:   if (arm_point) state_next = RUN;
      RUN:     if (line_end)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    r_c = pix_r;
    g_c = pix_g;
    b_c = pix_b;
    if (state == RUN) begin
      r_c = (hpos < RAMP_END) ? hpos[7:0] : 8'h00;
      g_c = r_c;
      b_c = r_c;
    end else if (blank_c) begin
      r_c = 8'h00;
      g_c = 8'h00;
      b_c = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hpos        <= 10'd0;
      vpos        <= 10'd0;
      state       <= IDLE;
      r           <= 8'h00;
      g           <= 8'h00;
      b           <= 8'h00;
      rn          <= 8'hFF;
      gn          <= 8'hFF;
      bn          <= 8'hFF;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      frame_start <= 1'b0;
      cal_busy    <= 1'b0;
      cal_done    <= 1'b0;
    end else begin
      if (line_end) begin
        hpos <= 10'd0;
        vpos <= (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
      end else begin
        hpos <= hpos + 10'd1;
      end
      state       <= state_next;
      r           <= r_c;
      g           <= g_c;
      b           <= b_c;
      rn          <= ~r_c;
      gn          <= ~g_c;
      bn          <= ~b_c;
      hsync       <= !((hpos >= HS_START) && (hpos < HS_END));
      vsync       <= !((vpos >= VS_START) && (vpos < VS_END));
      hblank      <= (hpos >= H_ACT);
      vblank      <= (vpos >= V_ACT);
      frame_start <= (hpos == 10'd0) && (vpos == 10'd0);
      cal_busy    <= (state_next != IDLE);
      cal_done    <= (state == RUN) && line_end;
    end
  end

endmodule

// File: tb/tb_vga_dac_sequencer.sv
// Scoreboard bench for vga_dac_sequencer using a shrunken raster (288x15) so that
// several frames fit in a short run; the ramp still spans the full 256 codes.
module tb_vga_dac_sequencer;

  localparam int HA = 256, HF = 8, HS = 16, HB = 8;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  localparam int RL = 256;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int W  = 77;

  // Handshake: the sequencer streams one result per clock with no backpressure,
  // so every clock edge after the driver's first push is an output beat.

  logic       clk, rst, cal_req;
  logic [7:0] pix_r, pix_g, pix_b;
  logic [9:0] hpos, vpos;
  logic [7:0] r, g, b, rn, gn, bn;
  logic       hsync, vsync, hblank, vblank, frame_start, cal_busy, cal_done;
  logic [1:0] cal_state;

  vga_dac_sequencer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .RAMP_LEN(RL)
  ) dut (
    .clk(clk), .rst(rst), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .cal_req(cal_req), .hpos(hpos), .vpos(vpos),
    .r(r), .g(g), .b(b), .rn(rn), .gn(gn), .bn(bn),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .frame_start(frame_start), .cal_busy(cal_busy), .cal_done(cal_done),
    .cal_state(cal_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int mh = 0, mv = 0, mst = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
    end
  endtask

  // driver: one raster clock, expected result pushed from the bench's own raster model
  task automatic step(input logic rst_v, input logic req_v,
                      input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
    logic [7:0] cr, cg, cb;
    logic hb, vb, hs_n, vs_n, fs, dn;
    int nh, nv, nst;
    @(negedge clk);
    rst = rst_v; cal_req = req_v; pix_r = pr; pix_g = pg; pix_b = pb;
    if (rst_v) begin
      exp_q.push_back({10'd0, 10'd0, 4'b1111, 3'b000, 2'd0, 24'h000000, 24'hFFFFFF});
      mh = 0; mv = 0; mst = 0;
    end else begin
      hb   = (mh >= HA);
      vb   = (mv >= VA);
      hs_n = !(mh >= HA + HF && mh < HA + HF + HS);
      vs_n = !(mv >= VA + VF && mv < VA + VF + VS);
      fs   = (mh == 0 && mv == 0);
      if (mst == 2) begin
        cr = (mh < RL) ? 8'(mh) : 8'h00;
        cg = cr; cb = cr;
      end else if (hb || vb) begin
        cr = 8'h00; cg = 8'h00; cb = 8'h00;
      end else begin
        cr = pr; cg = pg; cb = pb;
      end
      dn  = (mst == 2) && (mh == HT - 1);
      nst = mst;
      if (mst == 0 && req_v) nst = 1;
      else if (mst == 1 && mh == HT - 1 && mv == VA - 1) nst = 2;
      else if (mst == 2 && mh == HT - 1) nst = 0;
      nh = (mh == HT - 1) ? 0 : mh + 1;
      nv = (mh == HT - 1) ? ((mv == VT - 1) ? 0 : mv + 1) : mv;
      exp_q.push_back({10'(nh), 10'(nv), hs_n, vs_n, hb, vb, fs, (nst != 0), dn, 2'(nst),
                       cr, cg, cb, ~cr, ~cg, ~cb});
      mh = nh; mv = nv; mst = nst;
    end
  endtask

  task automatic step_rand(input logic req_v);
    step(1'b0, req_v, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
         8'($urandom_range(0, 255)));
  endtask

  task automatic advance_to(input int h, input int v);
    for (int n = 0; n < FR + 1 && !(mh == h && mv == v); n++) step_rand(1'b0);
  endtask

  // monitor / scoreboard
  logic [W-1:0] e;
  int hs_run = 0;
  int fs_cnt = 0;
  bit fs_valid = 0;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pos",         {hpos, vpos},                e[76:57]);
      check("sync_blank",  {hsync, vsync, hblank, vblank}, e[56:53]);
      check("frame_start", frame_start,                 e[52]);
      check("cal_busy",    cal_busy,                    e[51]);
      check("cal_done",    cal_done,                    e[50]);
      check("cal_state",   cal_state,                   e[49:48]);
      check("rgb",         {r, g, b},                   e[47:24]);
      check("rgb_n",       {rn, gn, bn},                e[23:0]);
      if (rst) begin
        hs_run = 0; fs_valid = 0; fs_cnt = 0;
      end else begin
        if (!hsync) hs_run++;
        else if (hs_run != 0) begin
          check("hsync_width", hs_run, HS);
          hs_run = 0;
        end
        if (frame_start) begin
          if (fs_valid) check("frame_period", fs_cnt, FR);
          fs_valid = 1; fs_cnt = 1;
        end else fs_cnt++;
      end
    end
  end

  initial begin
    rst = 1'b1; cal_req = 1'b0; pix_r = 8'h00; pix_g = 8'h00; pix_b = 8'h00;
    // reset held three cycles
    repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    // constant pixel for two frames
    repeat (2 * FR) step(1'b0, 1'b0, 8'hA5, 8'h3C, 8'h00);
    // single-cycle calibration request mid-frame
    advance_to(40, 3);
    step_rand(1'b1);
    repeat (FR + HT) step_rand(1'b0);
    // request on the arm cycle itself: ramp deferred one frame
    advance_to(HT - 1, VA - 1);
    step_rand(1'b1);
    repeat (2 * FR) step_rand(1'b0);
    // reset in the middle of the ramp line
    advance_to(0, 2);
    step_rand(1'b1);
    advance_to(100, VA);
    repeat (2) step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (FR + HT) step_rand(1'b0);
    // request held high across done re-arms every frame
    repeat (2 * FR + HT) step_rand(1'b1);
    repeat (HT) step_rand(1'b0);
    @(posedge clk);
    #2;
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
